// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaled period counter, edge/center alignment,
// per-channel polarity and shadowed period/duty/mode applied only at period boundaries.
module pwm_multi #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      center_mode,
    input  logic [CHANNELS-1:0]       polarity,
    input  logic                      update,
    output logic                      update_pending,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      cycle_start
);

    logic [PRESC_W-1:0]        presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]          counter_q, counter_d, counter_step;
    logic                      dir_down_q, dir_down_d, dir_step;
    logic [WIDTH-1:0]          period_a_q, period_s_q;
    logic [CHANNELS*WIDTH-1:0] duty_a_q, duty_s_q;
    logic                      center_a_q, center_s_q;
    logic                      pending_q, pending_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d, raw;
    logic                      cycle_start_q;
    logic                      tick, wrap, boundary, transfer;

    always_comb begin
        tick         = enable && (presc_cnt_q == prescale);
        counter_step = counter_q;
        dir_step     = dir_down_q;
        wrap         = 1'b0;
        if (period_a_q == '0) begin
            counter_step = '0;
            dir_step     = 1'b0;
            wrap         = 1'b1;
        end else if (!center_a_q) begin
            if (counter_q == period_a_q) begin
                counter_step = '0;
                wrap         = 1'b1;
            end else begin
                counter_step = counter_q + WIDTH'(1);
            end
        end else begin
            if (!dir_down_q && (counter_q != period_a_q)) begin
                counter_step = counter_q + WIDTH'(1);
            end else begin
                // Turning point at the top, or descending; landing on 0 ends the period.
                counter_step = counter_q - WIDTH'(1);
                dir_step     = 1'b1;
                if (counter_q == WIDTH'(1)) begin
                    dir_step = 1'b0;
                    wrap     = 1'b1;
                end
            end
        end

        boundary = tick && wrap;
        transfer = pending_q && (boundary || !enable);

        presc_cnt_d = presc_cnt_q;
        counter_d   = counter_q;
        dir_down_d  = dir_down_q;
        if (!enable) begin
            presc_cnt_d = '0;
            counter_d   = '0;
            dir_down_d  = 1'b0;
        end else if (tick) begin
            presc_cnt_d = '0;
            counter_d   = counter_step;
            dir_down_d  = dir_step;
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end

        pending_d = update || (pending_q && !transfer);

        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = counter_q < duty_a_q[i*WIDTH +: WIDTH];
        end
        pwm_d = enable ? (raw ^ polarity) : polarity;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt_q   <= '0;
            counter_q     <= '0;
            dir_down_q    <= 1'b0;
            period_a_q    <= '0;
            duty_a_q      <= '0;
            center_a_q    <= 1'b0;
            period_s_q    <= '0;
            duty_s_q      <= '0;
            center_s_q    <= 1'b0;
            pending_q     <= 1'b0;
            pwm_q         <= '0;
            cycle_start_q <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            counter_q   <= counter_d;
            dir_down_q  <= dir_down_d;
            // Old shadow moves to active before a same-clk update overwrites the shadow.
            if (transfer) begin
                period_a_q <= period_s_q;
                duty_a_q   <= duty_s_q;
                center_a_q <= center_s_q;
            end
            if (update) begin
                period_s_q <= period;
                duty_s_q   <= duty;
                center_s_q <= center_mode;
            end
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            cycle_start_q <= boundary;
        end
    end

    assign update_pending = pending_q;
    assign pwm_out        = pwm_q;
    assign cycle_start    = cycle_start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: closed-form waveform expectations queued per clock and
// compared against the registered outputs on the falling edge.
module tb_pwm_multi;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int PRESC_W  = 8;

    typedef struct packed {
        logic [CHANNELS-1:0] pwm;
        logic                cs;
        logic                pend;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      enable = 1'b0;
    logic [PRESC_W-1:0]        prescale = '0;
    logic [WIDTH-1:0]          period = '0;
    logic [CHANNELS*WIDTH-1:0] duty = '0;
    logic                      center_mode = 1'b0;
    logic [CHANNELS-1:0]       polarity = '0;
    logic                      update = 1'b0;
    logic                      update_pending;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      cycle_start;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .prescale      (prescale),
        .period        (period),
        .duty          (duty),
        .center_mode   (center_mode),
        .polarity      (polarity),
        .update        (update),
        .update_pending(update_pending),
        .pwm_out       (pwm_out),
        .cycle_start   (cycle_start)
    );

    // Counter value t ticks after a period start.
    function automatic int cnt_at(input int t, input int p, input bit ctr);
        int m;
        if (p == 0) return 0;
        if (!ctr) return t % (p + 1);
        m = t % (2 * p);
        return (m <= p) ? m : 2 * p - m;
    endfunction

    // pwm_out k clks after the cycle_start sample reflects the counter one clk earlier.
    function automatic logic [CHANNELS-1:0] pwm_at(input int k, input int p, input bit ctr,
                                                   input int ps,
                                                   input logic [CHANNELS*WIDTH-1:0] d,
                                                   input logic [CHANNELS-1:0] pol);
        int c;
        logic [CHANNELS-1:0] r;
        c = cnt_at((k - 1) / (ps + 1), p, ctr);
        for (int i = 0; i < CHANNELS; i++) r[i] = (c < int'(d[i*WIDTH +: WIDTH])) ^ pol[i];
        return r;
    endfunction

    function automatic logic cs_at(input int k, input int p, input bit ctr, input int ps);
        int n;
        n = (p == 0) ? 1 : (ctr ? 2 * p : p + 1);
        return (k % (n * (ps + 1))) == 0;
    endfunction

    task automatic wait_start(input string name);
        int n = 0;
        while (cycle_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cycle_start !== 1'b1) begin
            errors++;
            $display("FAIL %s: cycle_start got %b, want 1 within 2000 clks", name, cycle_start);
        end
    endtask

    // Load a configuration through the disabled path, then start running.
    task automatic configure(input int p, input logic [CHANNELS*WIDTH-1:0] d, input bit ctr,
                             input int ps, input logic [CHANNELS-1:0] pol);
        @(negedge clk);
        enable      = 1'b0;
        period      = WIDTH'(p);
        duty        = d;
        center_mode = ctr;
        prescale    = PRESC_W'(ps);
        polarity    = pol;
        update      = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic run_window(input string name, input int p, input bit ctr, input int ps,
                              input logic [CHANNELS*WIDTH-1:0] d,
                              input logic [CHANNELS-1:0] pol, input int ncyc);
        exp_t e, got;
        wait_start(name);
        for (int k = 1; k <= ncyc; k++)
            q.push_back(exp_t'{pwm: pwm_at(k, p, ctr, ps, d, pol), cs: cs_at(k, p, ctr, ps),
                               pend: 1'b0});
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            e   = q.pop_front();
            got = exp_t'{pwm: pwm_out, cs: cycle_start, pend: update_pending};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s k=%0d: got pwm=%b cs=%b pend=%b, want pwm=%b cs=%b pend=%b",
                         name, k, got.pwm, got.cs, got.pend, e.pwm, e.cs, e.pend);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks += 3;
        if (pwm_out !== '0) begin
            errors++;
            $display("FAIL reset_pwm: got %b want 0000", pwm_out);
        end
        if (cycle_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_cs: got %b want 0", cycle_start);
        end
        if (update_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pend: got %b want 0", update_pending);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({pwm_out, cycle_start, update_pending} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: got pwm=%b cs=%b pend=%b want all 0",
                     pwm_out, cycle_start, update_pending);
        end
    endtask

    task automatic test_edge();
        logic [CHANNELS*WIDTH-1:0] d = {8'd255, 8'd10, 8'd0, 8'd3};
        configure(9, d, 1'b0, 0, 4'b0000);
        run_window("edge", 9, 1'b0, 0, d, 4'b0000, 30);
        polarity = 4'b0101;
        run_window("edge_pol", 9, 1'b0, 0, d, 4'b0101, 20);
    endtask

    task automatic test_center();
        logic [CHANNELS*WIDTH-1:0] d = {8'd8, 8'd4, 8'd1, 8'd2};
        configure(4, d, 1'b1, 0, 4'b0000);
        run_window("center", 4, 1'b1, 0, d, 4'b0000, 24);
        configure(4, d, 1'b1, 2, 4'b0000);
        run_window("center_presc", 4, 1'b1, 2, d, 4'b0000, 72);
    endtask

    task automatic test_shadow();
        logic [CHANNELS*WIDTH-1:0] d3 = {8'd0, 8'd0, 8'd0, 8'd3};
        logic [CHANNELS*WIDTH-1:0] d5 = {8'd0, 8'd0, 8'd0, 8'd5};
        logic [CHANNELS*WIDTH-1:0] d6 = {8'd0, 8'd0, 8'd0, 8'd6};
        logic [CHANNELS*WIDTH-1:0] d7 = {8'd0, 8'd0, 8'd0, 8'd7};
        logic [CHANNELS*WIDTH-1:0] dk;
        exp_t e, got;
        configure(9, d3, 1'b0, 0, 4'b0000);
        wait_start("shadow");
        for (int k = 1; k <= 40; k++) begin
            dk = (k <= 10) ? d3 : ((k <= 20) ? d7 : d6);
            q.push_back(exp_t'{pwm: pwm_at(k, 9, 1'b0, 0, dk, 4'b0000), cs: cs_at(k, 9, 1'b0, 0),
                               pend: (k >= 6 && k <= 9) || (k >= 13 && k <= 19)});
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            e   = q.pop_front();
            got = exp_t'{pwm: pwm_out, cs: cycle_start, pend: update_pending};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL shadow k=%0d: got pwm=%b cs=%b pend=%b, want pwm=%b cs=%b pend=%b",
                         k, got.pwm, got.cs, got.pend, e.pwm, e.cs, e.pend);
            end
            if (k == 5) begin duty = d7; update = 1'b1; end
            else if (k == 12) begin duty = d5; update = 1'b1; end
            else if (k == 15) begin duty = d6; update = 1'b1; end
            else update = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [CHANNELS*WIDTH-1:0] d3 = {8'd0, 8'd0, 8'd0, 8'd3};
        logic [CHANNELS*WIDTH-1:0] d5 = {8'd0, 8'd0, 8'd0, 8'd5};
        logic [CHANNELS*WIDTH-1:0] d6 = {8'd0, 8'd0, 8'd0, 8'd6};
        logic [CHANNELS*WIDTH-1:0] dk;
        exp_t e, got;
        configure(9, d3, 1'b0, 0, 4'b0000);
        wait_start("same_clk");
        for (int k = 1; k <= 32; k++) begin
            dk = (k <= 10) ? d3 : ((k <= 20) ? d5 : d6);
            q.push_back(exp_t'{pwm: pwm_at(k, 9, 1'b0, 0, dk, 4'b0000), cs: cs_at(k, 9, 1'b0, 0),
                               pend: (k >= 4 && k <= 19)});
        end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            e   = q.pop_front();
            got = exp_t'{pwm: pwm_out, cs: cycle_start, pend: update_pending};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL same_clk k=%0d: got pwm=%b cs=%b pend=%b, want pwm=%b cs=%b pend=%b",
                         k, got.pwm, got.cs, got.pend, e.pwm, e.cs, e.pend);
            end
            // The k=9 update lands on the same clk as the boundary tick.
            if (k == 3) begin duty = d5; update = 1'b1; end
            else if (k == 9) begin duty = d6; update = 1'b1; end
            else update = 1'b0;
        end
    endtask

    task automatic test_enable();
        logic [CHANNELS*WIDTH-1:0] d3 = {8'd0, 8'd0, 8'd0, 8'd3};
        logic [CHANNELS*WIDTH-1:0] d4 = {8'd0, 8'd0, 8'd0, 8'd4};
        exp_t e, got;
        configure(9, d3, 1'b0, 0, 4'b0000);
        wait_start("enable");
        q.push_back(exp_t'{pwm: 4'b0001, cs: 1'b0, pend: 1'b1});
        q.push_back(exp_t'{pwm: 4'b1010, cs: 1'b0, pend: 1'b0});
        q.push_back(exp_t'{pwm: 4'b1010, cs: 1'b0, pend: 1'b0});
        q.push_back(exp_t'{pwm: 4'b0110, cs: 1'b0, pend: 1'b0});
        @(negedge clk);
        duty   = d4;
        update = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            e   = q.pop_front();
            got = exp_t'{pwm: pwm_out, cs: cycle_start, pend: update_pending};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL enable s=%0d: got pwm=%b cs=%b pend=%b, want pwm=%b cs=%b pend=%b",
                         s, got.pwm, got.cs, got.pend, e.pwm, e.cs, e.pend);
            end
            if (s == 0) begin update = 1'b0; enable = 1'b0; polarity = 4'b1010; end
            if (s == 2) polarity = 4'b0110;
        end
        enable = 1'b1;
        run_window("enable_resume", 9, 1'b0, 0, d4, 4'b0110, 20);
    endtask

    task automatic test_reset_mid();
        logic [CHANNELS*WIDTH-1:0] d3 = {8'd0, 8'd0, 8'd0, 8'd3};
        logic [CHANNELS*WIDTH-1:0] d8 = {8'd0, 8'd0, 8'd0, 8'd8};
        exp_t e, got;
        configure(9, d3, 1'b0, 0, 4'b0000);
        wait_start("reset_mid");
        @(negedge clk);
        duty   = d8;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        checks++;
        if ({pwm_out, cycle_start, update_pending} !== {4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_pre: got pwm=%b cs=%b pend=%b want pwm=0001 cs=0 pend=1",
                     pwm_out, cycle_start, update_pending);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out, cycle_start, update_pending} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got pwm=%b cs=%b pend=%b want all 0",
                     pwm_out, cycle_start, update_pending);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Active period/duty are 0 again: every tick is a boundary, outputs inactive.
        for (int s = 0; s < 5; s++) q.push_back(exp_t'{pwm: 4'b0000, cs: 1'b1, pend: 1'b0});
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            e   = q.pop_front();
            got = exp_t'{pwm: pwm_out, cs: cycle_start, pend: update_pending};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_after s=%0d: got pwm=%b cs=%b pend=%b, want pwm=%b cs=%b pend=%b",
                         s, got.pwm, got.cs, got.pend, e.pwm, e.cs, e.pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
